// File: rtl/landrover_pkg.sv
// Shared state and command encodings for the landrover drive controller.
package landrover_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_DRIVE = 3'b001,
        ST_BRAKE = 3'b010,
        ST_TURN  = 3'b011,
        ST_ESTOP = 3'b100
    } state_e;

    typedef enum logic [1:0] {
        CMD_HOLD    = 2'b00,
        CMD_ACCEL   = 2'b01,
        CMD_DECEL   = 2'b10,
        CMD_REVERSE = 2'b11
    } cmd_e;

    // Bits needed to hold the value n (at least one).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/landrover_timer.sv
// Loadable down-counter that stops at zero and flags it; used for dwell and turn timing.
module landrover_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/landrover_drive_fsm.sv
// Drive controller: accepts speed/direction commands, brakes and turns on reverse, stops on obstacles.
module landrover_drive_fsm
    import landrover_pkg::*;
#(
    parameter int SPEED_W     = 3,
    parameter int DWELL       = 4,
    parameter int TURN_CYCLES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd,
    input  logic               obstacle,
    output logic               cmd_ready,
    output logic [2:0]         state,
    output logic [SPEED_W-1:0] speed,
    output logic               dir
);

    localparam logic [SPEED_W-1:0] SMAX       = {SPEED_W{1'b1}};
    localparam logic [SPEED_W-1:0] ONE        = SPEED_W'(1);
    localparam int                 DW_W       = cnt_width(DWELL);
    localparam int                 TN_W       = cnt_width(TURN_CYCLES);
    localparam logic [DW_W-1:0]    DWELL_LOAD = DW_W'(DWELL);
    // The counter is checked while already in TURN, so it starts one short.
    localparam logic [TN_W-1:0]    TURN_LOAD  = TN_W'(TURN_CYCLES - 1);

    state_e             state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               dir_q, dir_d;
    logic               rev_q, rev_d;
    logic               dwell_load, dwell_clr, dwell_zero;
    logic               turn_load, turn_clr, turn_zero;
    logic               accept;

    assign cmd_ready = !reset && (state_q == ST_IDLE || state_q == ST_DRIVE)
                       && dwell_zero && !obstacle;
    assign accept    = cmd_valid && cmd_ready;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        speed_d    = speed_q;
        dir_d      = dir_q;
        rev_d      = rev_q;
        dwell_load = 1'b0;
        dwell_clr  = 1'b0;
        turn_load  = 1'b0;
        turn_clr   = 1'b0;

        if (obstacle && (state_q == ST_DRIVE || state_q == ST_BRAKE || state_q == ST_TURN)) begin
            state_d   = ST_ESTOP;
            speed_d   = '0;
            rev_d     = 1'b0;
            dwell_clr = 1'b1;
            turn_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    speed_d = '0;
                    if (accept) begin
                        case (cmd_e'(cmd))
                            CMD_ACCEL: begin
                                state_d    = ST_DRIVE;
                                speed_d    = ONE;
                                dwell_load = 1'b1;
                            end
                            CMD_DECEL:   dwell_load = 1'b1;
                            CMD_REVERSE: dir_d = !dir_q;
                            default: ;
                        endcase
                    end
                end
                ST_DRIVE: begin
                    if (accept) begin
                        case (cmd_e'(cmd))
                            CMD_ACCEL: begin
                                if (speed_q != SMAX) speed_d = speed_q + ONE;
                                dwell_load = 1'b1;
                            end
                            CMD_DECEL: begin
                                dwell_load = 1'b1;
                                if (speed_q <= ONE) begin
                                    speed_d = '0;
                                    state_d = ST_IDLE;
                                end else begin
                                    speed_d = speed_q - ONE;
                                end
                            end
                            CMD_REVERSE: begin
                                state_d = ST_BRAKE;
                                rev_d   = 1'b1;
                                if (speed_q != '0) speed_d = speed_q - ONE;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_BRAKE: begin
                    if (speed_q == '0) begin
                        if (rev_q) begin
                            state_d   = ST_TURN;
                            turn_load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        speed_d = speed_q - ONE;
                    end
                end
                ST_TURN: begin
                    speed_d = '0;
                    if (turn_zero) begin
                        state_d = ST_DRIVE;
                        speed_d = ONE;
                        dir_d   = !dir_q;
                        rev_d   = 1'b0;
                    end
                end
                ST_ESTOP: begin
                    speed_d = '0;
                    if (!obstacle) state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    speed_d = '0;
                end
            endcase
        end
    end

    // NOTE: non-blocking assignments make every register update from its pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            speed_q <= '0;
            dir_q   <= 1'b0;
            rev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            dir_q   <= dir_d;
            rev_q   <= rev_d;
        end
    end

    landrover_timer #(.W(DW_W)) u_dwell_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (dwell_load),
        .clear    (dwell_clr),
        .load_val (DWELL_LOAD),
        .zero     (dwell_zero)
    );

    landrover_timer #(.W(TN_W)) u_turn_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (turn_load),
        .clear    (turn_clr),
        .load_val (TURN_LOAD),
        .zero     (turn_zero)
    );

    assign state = state_q;
    assign speed = speed_q;
    assign dir   = dir_q;

endmodule

// File: tb/tb_landrover_drive_fsm.sv
// Directed scenarios plus a randomized run against a cycle-level behavioural model.
module tb_landrover_drive_fsm;

    localparam logic [2:0] S_IDLE = 3'd0, S_DRIVE = 3'd1, S_BRAKE = 3'd2, S_TURN = 3'd3, S_ESTOP = 3'd4;
    localparam logic [1:0] C_HOLD = 2'd0, C_ACCEL = 2'd1, C_DECEL = 2'd2, C_REV = 2'd3;
    localparam int DWELL = 4, TURN_CYCLES = 8, SMAX = 7;

    logic       clk, reset, cmd_valid, obstacle, cmd_ready, dir;
    logic [1:0] cmd;
    logic [2:0] state, speed;

    logic       cmd_valid2, obstacle2, cmd_ready2, dir2;
    logic [1:0] cmd2;
    logic [2:0] state2;
    logic [1:0] speed2;

    int total  = 0;
    int passed = 0;

    landrover_drive_fsm dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .obstacle(obstacle),
        .cmd_ready(cmd_ready), .state(state), .speed(speed), .dir(dir)
    );

    landrover_drive_fsm #(.SPEED_W(2)) dut2 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd(cmd2), .obstacle(obstacle2),
        .cmd_ready(cmd_ready2), .state(state2), .speed(speed2), .dir(dir2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: st uses the output encoding, turn_left counts TURN cycles still to spend.
    typedef struct {
        int st;
        int spd;
        bit dir;
        bit rev;
        int dwell;
        int turn_left;
    } mdl_t;

    mdl_t m;

    function automatic bit m_ready(input mdl_t x, input bit r, input bit o);
        return !r && (x.st == 0 || x.st == 1) && x.dwell == 0 && !o;
    endfunction

    function automatic mdl_t m_step(input mdl_t x, input bit r, input bit v, input logic [1:0] c, input bit o);
        mdl_t n;
        bit   acc;
        n   = x;
        acc = v && m_ready(x, r, o);
        if (r) begin
            n.st = 0; n.spd = 0; n.dir = 0; n.rev = 0; n.dwell = 0; n.turn_left = 0;
            return n;
        end
        if (n.dwell > 0) n.dwell--;
        if (o && (x.st == 1 || x.st == 2 || x.st == 3)) begin
            n.st = 4; n.spd = 0; n.rev = 0; n.dwell = 0; n.turn_left = 0;
            return n;
        end
        case (x.st)
            0: if (acc) begin
                if (c == C_ACCEL) begin n.st = 1; n.spd = 1; end
                if (c == C_REV) n.dir = !x.dir;
                if (c == C_ACCEL || c == C_DECEL) n.dwell = DWELL;
            end
            1: if (acc) begin
                if (c == C_ACCEL) n.spd = (x.spd < SMAX) ? x.spd + 1 : SMAX;
                if (c == C_DECEL) begin
                    n.spd = (x.spd > 0) ? x.spd - 1 : 0;
                    if (n.spd == 0) n.st = 0;
                end
                if (c == C_REV) begin
                    n.st = 2; n.rev = 1;
                    n.spd = (x.spd > 0) ? x.spd - 1 : 0;
                end
                if (c == C_ACCEL || c == C_DECEL) n.dwell = DWELL;
            end
            2: if (x.spd == 0) begin
                n.st = x.rev ? 3 : 0;
                n.turn_left = TURN_CYCLES;
            end else begin
                n.spd = x.spd - 1;
            end
            3: begin
                n.turn_left = x.turn_left - 1;
                if (n.turn_left == 0) begin
                    n.st = 1; n.spd = 1; n.dir = !x.dir; n.rev = 0;
                end
            end
            4: if (!o) n.st = 0;
            default: n.st = 0;
        endcase
        return n;
    endfunction

    task automatic apply(input bit r, input bit v, input logic [1:0] c, input bit o);
        reset = r; cmd_valid = v; cmd = c; obstacle = o;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply(1, 1, C_ACCEL, 0);
        total++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready_high: got %b expected 0", cmd_ready); else passed++;
        edge_step();
        total++; if (state !== S_IDLE) $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); else passed++;
        total++; if (speed !== 3'd0) $display("FAIL reset_speed: got %0d expected 0", speed); else passed++;
        total++; if (dir !== 1'b0) $display("FAIL reset_dir: got %b expected 0", dir); else passed++;
        apply(0, 0, C_HOLD, 0);
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready_after: got %b expected 1", cmd_ready); else passed++;
    endtask

    task automatic test_accel_dwell();
        logic exp_rdy;
        for (int i = 0; i < 15; i++) begin
            apply(0, 1, C_ACCEL, 0);
            exp_rdy = (i % 5 == 0);
            total++; if (cmd_ready !== exp_rdy) $display("FAIL accel_ready[%0d]: got %b expected %b", i, cmd_ready, exp_rdy); else passed++;
            edge_step();
            total++; if (speed !== 3'(i / 5 + 1)) $display("FAIL accel_speed[%0d]: got %0d expected %0d", i, speed, i / 5 + 1); else passed++;
        end
        apply(0, 0, C_HOLD, 0);
        total++; if (state !== S_DRIVE) $display("FAIL accel_state: got %0d expected %0d", state, S_DRIVE); else passed++;
    endtask

    task automatic test_saturate();
        int accepts;
        int max_sp;
        accepts = 0;
        max_sp  = 0;
        cmd_valid2 = 1'b1; cmd2 = C_ACCEL;
        for (int i = 0; i < 25; i++) begin
            apply(0, 0, C_HOLD, 0);
            if (cmd_ready2 === 1'b1) accepts++;
            edge_step();
            if (int'(speed2) > max_sp) max_sp = int'(speed2);
        end
        cmd_valid2 = 1'b0;
        total++; if (accepts != 5) $display("FAIL sat_accepts: got %0d expected 5", accepts); else passed++;
        total++; if (speed2 !== 2'd3) $display("FAIL sat_speed: got %0d expected 3", speed2); else passed++;
        total++; if (max_sp != 3) $display("FAIL sat_max_speed: got %0d expected 3", max_sp); else passed++;
        total++; if (state2 !== S_DRIVE) $display("FAIL sat_state: got %0d expected %0d", state2, S_DRIVE); else passed++;
    endtask

    task automatic test_reverse_turn();
        int exp_st[12];
        int exp_sp[12];
        exp_st = '{2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3, 1};
        exp_sp = '{2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        apply(0, 0, C_HOLD, 0);
        repeat (DWELL + 1) edge_step();
        total++; if (speed !== 3'd3 || dir !== 1'b0) $display("FAIL rev_start: got speed %0d dir %b expected 3 0", speed, dir); else passed++;
        apply(0, 1, C_REV, 0);
        total++; if (cmd_ready !== 1'b1) $display("FAIL rev_ready: got %b expected 1", cmd_ready); else passed++;
        edge_step();
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                apply(0, 0, C_HOLD, 0);
                edge_step();
            end
            total++; if (state !== 3'(exp_st[k])) $display("FAIL rev_state[%0d]: got %0d expected %0d", k, state, exp_st[k]); else passed++;
            total++; if (speed !== 3'(exp_sp[k])) $display("FAIL rev_speed[%0d]: got %0d expected %0d", k, speed, exp_sp[k]); else passed++;
        end
        total++; if (dir !== 1'b1) $display("FAIL rev_dir: got %b expected 1", dir); else passed++;
    endtask

    task automatic test_obstacle_turn();
        apply(1, 0, C_HOLD, 0); edge_step();
        apply(0, 1, C_ACCEL, 0); edge_step();
        apply(0, 0, C_HOLD, 0); repeat (DWELL) edge_step();
        apply(0, 1, C_REV, 0); edge_step();
        total++; if (state !== S_BRAKE || speed !== 3'd0) $display("FAIL obs_brake: got state %0d speed %0d expected 2 0", state, speed); else passed++;
        apply(0, 0, C_HOLD, 0); repeat (3) edge_step();
        total++; if (state !== S_TURN) $display("FAIL obs_in_turn: got %0d expected %0d", state, S_TURN); else passed++;
        apply(0, 1, C_ACCEL, 1);
        total++; if (cmd_ready !== 1'b0) $display("FAIL obs_ready: got %b expected 0", cmd_ready); else passed++;
        edge_step();
        total++; if (state !== S_ESTOP) $display("FAIL obs_estop: got %0d expected %0d", state, S_ESTOP); else passed++;
        total++; if (speed !== 3'd0 || dir !== 1'b0) $display("FAIL obs_speed_dir: got %0d %b expected 0 0", speed, dir); else passed++;
        edge_step();
        total++; if (state !== S_ESTOP) $display("FAIL obs_hold: got %0d expected %0d", state, S_ESTOP); else passed++;
        apply(0, 1, C_ACCEL, 0);
        total++; if (cmd_ready !== 1'b0) $display("FAIL obs_estop_ready: got %b expected 0", cmd_ready); else passed++;
        edge_step();
        total++; if (state !== S_IDLE || speed !== 3'd0) $display("FAIL obs_release: got state %0d speed %0d expected 0 0", state, speed); else passed++;
        apply(0, 0, C_HOLD, 0);
        total++; if (cmd_ready !== 1'b1) $display("FAIL obs_idle_ready: got %b expected 1", cmd_ready); else passed++;
    endtask

    task automatic test_reset_brake();
        apply(1, 0, C_HOLD, 0); edge_step();
        apply(0, 1, C_REV, 0); edge_step();
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, C_ACCEL, 0); edge_step();
            apply(0, 0, C_HOLD, 0); repeat (DWELL) edge_step();
        end
        apply(0, 1, C_REV, 0); edge_step();
        total++; if (state !== S_BRAKE || speed !== 3'd2 || dir !== 1'b1) $display("FAIL rstb_setup: got state %0d speed %0d dir %b expected 2 2 1", state, speed, dir); else passed++;
        apply(1, 1, C_ACCEL, 0);
        total++; if (cmd_ready !== 1'b0) $display("FAIL rstb_ready0: got %b expected 0", cmd_ready); else passed++;
        edge_step();
        total++; if (state !== S_IDLE || speed !== 3'd0 || dir !== 1'b0) $display("FAIL rstb_outputs: got state %0d speed %0d dir %b expected 0 0 0", state, speed, dir); else passed++;
        apply(1, 1, C_ACCEL, 0);
        total++; if (cmd_ready !== 1'b0) $display("FAIL rstb_ready1: got %b expected 0", cmd_ready); else passed++;
        edge_step();
        total++; if (state !== S_IDLE || speed !== 3'd0) $display("FAIL rstb_held: got state %0d speed %0d expected 0 0", state, speed); else passed++;
        apply(0, 0, C_HOLD, 0);
        total++; if (cmd_ready !== 1'b1) $display("FAIL rstb_release: got %b expected 1", cmd_ready); else passed++;
    endtask

    task automatic test_decel_idle();
        apply(1, 0, C_HOLD, 0); edge_step();
        apply(0, 1, C_ACCEL, 0); edge_step();
        apply(0, 0, C_HOLD, 0); repeat (DWELL) edge_step();
        apply(0, 1, C_DECEL, 0);
        total++; if (cmd_ready !== 1'b1) $display("FAIL decel_ready: got %b expected 1", cmd_ready); else passed++;
        edge_step();
        total++; if (state !== S_IDLE || speed !== 3'd0) $display("FAIL decel_idle: got state %0d speed %0d expected 0 0", state, speed); else passed++;
        for (int k = 0; k < DWELL; k++) begin
            apply(0, 1, C_REV, 0);
            total++; if (cmd_ready !== 1'b0) $display("FAIL decel_dwell[%0d]: got %b expected 0", k, cmd_ready); else passed++;
            edge_step();
        end
        total++; if (dir !== 1'b0) $display("FAIL decel_no_toggle: got %b expected 0", dir); else passed++;
        apply(0, 1, C_REV, 0);
        edge_step();
        total++; if (state !== S_IDLE || dir !== 1'b1) $display("FAIL idle_reverse: got state %0d dir %b expected 0 1", state, dir); else passed++;
        apply(0, 1, C_ACCEL, 1);
        total++; if (cmd_ready !== 1'b0) $display("FAIL idle_obs_ready: got %b expected 0", cmd_ready); else passed++;
        edge_step();
        total++; if (state !== S_IDLE || speed !== 3'd0) $display("FAIL idle_obs_state: got state %0d speed %0d expected 0 0", state, speed); else passed++;
    endtask

    task automatic test_random();
        bit         r, v, o;
        logic [1:0] c;
        apply(1, 0, C_HOLD, 0);
        m = m_step(m, 1, 0, C_HOLD, 0);
        edge_step();
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) != 0);
            c = 2'($urandom_range(0, 3));
            o = ($urandom_range(0, 15) == 0);
            apply(r, v, c, o);
            total++; if (cmd_ready !== m_ready(m, r, o)) $display("FAIL rnd_ready[%0d]: got %b expected %b", i, cmd_ready, m_ready(m, r, o)); else passed++;
            m = m_step(m, r, v, c, o);
            edge_step();
            total++; if (state !== 3'(m.st)) $display("FAIL rnd_state[%0d]: got %0d expected %0d", i, state, m.st); else passed++;
            total++; if (speed !== 3'(m.spd)) $display("FAIL rnd_speed[%0d]: got %0d expected %0d", i, speed, m.spd); else passed++;
            total++; if (dir !== m.dir) $display("FAIL rnd_dir[%0d]: got %b expected %b", i, dir, m.dir); else passed++;
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd = C_HOLD; obstacle = 1'b0;
        cmd_valid2 = 1'b0; cmd2 = C_HOLD; obstacle2 = 1'b0;
        @(negedge clk);
        test_reset();
        test_saturate();
        test_accel_dwell();
        test_reverse_turn();
        test_obstacle_turn();
        test_reset_brake();
        test_decel_idle();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/landrover_drive_fsm.md
LANDROVER_DRIVE_FSM -- requirements
Module: landrover_drive_fsm

Interface
REQ-001 SHALL have parameter SPEED_W, default 3: speed field width; max speed SMAX = 2^SPEED_W-1.
REQ-002 SHALL have parameter DWELL, default 4: cycles cmd_ready stays low after an accepted accel/decel (min 1).
REQ-003 SHALL have parameter TURN_CYCLES, default 8: cycles spent in TURN (min 1).
REQ-004 SHALL have port clk  input  1  sole clock, all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd  input  2  command: 00 HOLD, 01 ACCEL, 10 DECEL, 11 REVERSE.
REQ-008 SHALL have port obstacle  input  1  obstacle detected, level-sensitive.
REQ-009 SHALL have port cmd_ready  output  1  command accepted this cycle if cmd_valid also high.
REQ-010 SHALL have port state  output  3  registered FSM state: IDLE 000, DRIVE 001, BRAKE 010, TURN 011, ESTOP 100.
REQ-011 SHALL have port speed  output  SPEED_W  registered current speed.
REQ-012 SHALL have port dir  output  1  0 forward, 1 reverse.

Function
REQ-013 A command SHALL be accepted only on a clk edge with cmd_valid=1 and cmd_ready=1; effects SHALL be visible on outputs the following cycle.
REQ-014 cmd_ready SHALL be combinational: 1 only in IDLE or DRIVE, with dwell counter zero and obstacle=0.
REQ-015 IDLE: speed=0; ACCEL -> DRIVE, speed=1; REVERSE -> toggle dir, stay IDLE; HOLD/DECEL -> no change.
REQ-016 DRIVE: ACCEL -> speed+1 saturating at SMAX; DECEL -> speed-1, and speed reaching 0 -> IDLE; HOLD -> no change; REVERSE -> BRAKE with reverse-pending flag set.
REQ-017 Accepted ACCEL or DECEL (including saturated/no-op ACCEL at SMAX) SHALL load dwell counter with DWELL, counting down 1/cycle; cmd_ready low while nonzero.
REQ-018 BRAKE: speed SHALL decrement by 1 each cycle; on the cycle speed is 0 -> TURN if reverse pending, else IDLE; speed entering BRAKE at 1 reaches 0 in one cycle.
REQ-019 TURN: speed=0 for exactly TURN_CYCLES cycles; then dir toggles, reverse-pending clears, state -> DRIVE with speed=1.
REQ-020 obstacle=1 in DRIVE, BRAKE or TURN SHALL force ESTOP and speed=0 on the next edge, clearing reverse-pending and dwell counter; dir unchanged.
REQ-021 obstacle=1 in IDLE SHALL keep IDLE with cmd_ready=0.
REQ-022 ESTOP SHALL hold while obstacle=1; first edge with obstacle=0 -> IDLE.
REQ-023 Precedence SHALL be reset > obstacle > accepted command > internal timers.
REQ-024 speed arithmetic SHALL never wrap: no increment above SMAX, no decrement below 0.

Reset
REQ-025 reset=1 at a clk edge SHALL set state=IDLE, speed=0, dir=0, dwell and turn counters=0, reverse-pending=0, regardless of current state, including mid-BRAKE or mid-TURN.
REQ-026 cmd_ready SHALL be 0 while reset is high.
REQ-027 No power-on initial values SHALL be relied upon; reset is the only initialisation.

Structure
REQ-028 State encodings and cmd codes SHALL live in shared package landrover_pkg.
REQ-029 Dwell and turn timing SHALL use one reusable sub-module landrover_timer (loadable down-counter, zero flag), instantiated twice.

Verification
REQ-030 Reset, ACCEL x3 with cmd_valid held -> speed 1,2,3 with cmd_ready low 4 cycles between accepts.
REQ-031 SPEED_W=2, ACCEL x5 -> speed saturates at 3, state DRIVE.
REQ-032 Speed 3 fwd, REVERSE -> BRAKE speed 2,1,0, TURN 8 cycles, then DRIVE speed 1 dir=1.
REQ-033 obstacle=1 mid-TURN -> next cycle ESTOP speed 0 dir=0; obstacle=0 -> IDLE next cycle.
REQ-034 reset asserted mid-BRAKE at speed 2 -> next cycle IDLE, speed 0, dir 0, cmd_ready 0 until reset low.
REQ-035 Speed 1, DECEL -> IDLE speed 0; REVERSE in IDLE -> dir toggles, state IDLE.
